serial_magnitude_compare_ctrl: RTL and testbench
================================================

Name: serial_magnitude_compare_ctrl

Overview:
- Sequencer for a wide unsigned magnitude comparison built from one 3-bit digit comparison per cycle.
- Latches two (3*DIGITS)-bit operands on a start request and walks the 3-bit digits MSB-first. Reports greater/less/equal with a one-cycle done pulse.
- Sits between operand producers (register file, sort/max-find sequencers) and the shared 3-bit compare datapath. Trades latency for area.

Parameters:
- DIGITS, 4, number of 3-bit digits; operand width W = 3*DIGITS; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  3*DIGITS  operand A, unsigned; sampled on the accepting edge.
- B  input  3*DIGITS  operand B, unsigned; sampled on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- Greater  output  1  A > B.
- Less  output  1  A < B.
- Equal  output  1  A == B.
- digit_idx  output  clog2(DIGITS) (min 1)  digit currently being compared; debug.

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset rst is synchronous and active-high.
  - rst takes priority over everything and forces state IDLE.
  - Reset values: busy=0, done=0, Greater=0, Less=0, Equal=0, digit_idx=0.
  - Internal operand registers are cleared on reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch A and B, set digit_idx=DIGITS-1, clear Greater/Less/Equal and the internal "decided" flag, go to RUN.
  - start=0: stay in IDLE, results hold.
- RUN: each edge compares digit d = bits [3d+2:3d] of the latched operands.
  - If the digit is unequal and not yet decided: set Greater or Less per the digit result, set decided.
  - Once decided, later digits are ignored; the first unequal digit from the MSB determines the result.
  - If d==0: go to DONE. If no digit was unequal, set Equal=1. Otherwise decrement digit_idx.
- DONE:
  - done=1 for exactly this one cycle; go to IDLE on the next edge.
- Results:
  - Greater, Less and Equal stay stable from DONE until the next accepted start, which clears them.
  - Whenever done=1, exactly one of the three is high.
- Handshake:
  - start is ignored in RUN and DONE; it is not queued.
  - A and B may change freely after the accepting edge.
  - Back-to-back operation: start held high in IDLE gives one operation every DIGITS+2 cycles (baseline).
- Latency (baseline): with start accepted at edge E0, digits are compared at edges E1..E_DIGITS, and done is high in the cycle after edge E_DIGITS.
- Boundaries:
  - DIGITS=1 gives a single RUN cycle.
  - All-zero or all-ones operands are handled normally; there is no signed interpretation.
  - rst asserted mid-RUN or in DONE aborts: no done pulse, all outputs go to 0.
  - rst and start high together: reset wins and start is dropped.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - RUN goes to DONE on the first unequal digit; lower digits are skipped.
  - Latency is k+1 cycles to done, where k = number of digits examined (1..DIGITS).
  - Equal operands still take the full DIGITS.
- Undefined:
  - Fixed latency of DIGITS compare cycles regardless of data (constant-time).
  - Results are identical in both builds; only the timing of done differs.

Test Plan (DIGITS=4, operands in octal, 12-bit):
1. Reset, then idle 3 cycles -> all outputs 0, done never asserts.
2. A=o7000, B=o6777, start pulse -> Greater=1, Less=0, Equal=0.
   - Baseline: done in cycle E0+5.
   - With SERIAL_CMP_EARLY_EXIT_EN: done in cycle E0+2.
3. A=o1234, B=o1235 -> Less=1; done at E0+5 in both builds, since the difference is in the last digit.
4. A=B=o5252 -> Equal=1, done at E0+5; then A=o0000, B=o7777 back-to-back with start held high -> second result Less=1, and exactly one start is accepted per operation.
5. Change A and B and pulse start during RUN -> result reflects the originally latched operands and the extra start is ignored. Assert rst for 1 cycle mid-RUN -> no done pulse, outputs 0, next start works normally.
6. Randomised sweep of 1000 pairs against the golden relation A>B, A<B, A==B -> one-hot results match, and done pulse width is always 1.

Source files
------------

// File: rtl/serial_magnitude_compare_ctrl.sv
// serial_magnitude_compare_ctrl
// Compares two unsigned (3*DIGITS)-bit operands one 3-bit digit per cycle, MSB first.
// The first unequal digit from the top decides the result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only in IDLE
//   A, B       operands, latched on the accepting edge
//   busy       high in RUN and DONE
//   done       one-cycle pulse, result valid
//   Greater    A > B
//   Less       A < B
//   Equal      A == B
//   digit_idx  digit currently being compared (debug)
//
// Optional build macro: SERIAL_CMP_EARLY_EXIT_EN
//   defined   -> RUN ends on the first unequal digit (data-dependent latency)
//   undefined -> always DIGITS compare cycles (constant-time)
module serial_magnitude_compare_ctrl #(
   parameter int unsigned DIGITS = 4,
   localparam int unsigned W  = 3 * DIGITS,
   localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   output logic          busy,
   output logic          done,
   output logic          Greater,
   output logic          Less,
   output logic          Equal,
   output logic [IW-1:0] digit_idx
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]   state;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic         decided;
   logic [2:0]   a_dig;
   logic [2:0]   b_dig;
   logic         last_step;

   // Digit mux over the latched operands.
   always_comb begin
      a_dig = 3'd0;
      b_dig = 3'd0;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (digit_idx == IW'(d)) begin
            a_dig = a_q[3*d +: 3];
            b_dig = b_q[3*d +: 3];
         end
      end
   end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   // Leave RUN as soon as a digit decides the result.
   assign last_step = (digit_idx == '0) || (!decided && (a_dig != b_dig));
`else
   assign last_step = (digit_idx == '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         decided   <= 1'b0;
         Greater   <= 1'b0;
         Less      <= 1'b0;
         Equal     <= 1'b0;
         digit_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q       <= A;
                  b_q       <= B;
                  digit_idx <= IW'(DIGITS - 1);
                  Greater   <= 1'b0;
                  Less      <= 1'b0;
                  Equal     <= 1'b0;
                  decided   <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (!decided && (a_dig > b_dig)) begin
                  Greater <= 1'b1;
                  decided <= 1'b1;
               end
               if (!decided && (a_dig < b_dig)) begin
                  Less    <= 1'b1;
                  decided <= 1'b1;
               end
               if (last_step) begin
                  state <= DONE;
                  // Nothing differed in any digit, including this one.
                  if (!decided && (a_dig == b_dig)) begin
                     Equal <= 1'b1;
                  end
               end else begin
                  digit_idx <= digit_idx - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_compare_ctrl.sv
// Self-checking bench for serial_magnitude_compare_ctrl (DIGITS=4, 12-bit operands).
// Honours SERIAL_CMP_EARLY_EXIT_EN when computing expected latency.
module tb_serial_magnitude_compare_ctrl;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned W      = 3 * DIGITS;
   localparam int unsigned IW     = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          busy;
   logic          done;
   logic          Greater;
   logic          Less;
   logic          Equal;
   logic [IW-1:0] digit_idx;

   int checks = 0;
   int fails  = 0;

   serial_magnitude_compare_ctrl #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .A         (A),
      .B         (B),
      .busy      (busy),
      .done      (done),
      .Greater   (Greater),
      .Less      (Less),
      .Equal     (Equal),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: digit d of an operand by plain arithmetic.
   function automatic int digit_of(input int v, input int d);
      return (v / (8 ** d)) % 8;
   endfunction

   // Cycles from accepting edge to the done cycle.
   function automatic int ref_latency(input int a, input int b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      for (int d = DIGITS - 1; d >= 0; d--) begin
         if (digit_of(a, d) != digit_of(b, d)) return (DIGITS - d) + 1;
      end
      return DIGITS + 1;
`else
      if (a == b) return DIGITS + 1;
      return DIGITS + 1;
`endif
   endfunction

   // Call right after the accepting edge; returns at the negedge of the done cycle.
   task automatic wait_done(input string tag, input int exp_lat,
                            input logic eg, input logic el, input logic ee);
      int  lat;
      bit  found;
      bit  busy_bad;
      lat      = -1;
      found    = 0;
      busy_bad = 0;
      for (int n = 1; n <= 40 && !found; n++) begin
         @(negedge clk);
         if (done) begin
            found = 1;
            lat   = n;
         end
         if (!busy) busy_bad = 1;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy"}, {31'd0, busy_bad}, 32'd0);
      chk({tag, " result"}, {29'd0, Greater, Less, Equal}, {29'd0, eg, el, ee});
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      wait_done(tag, ref_latency(int'(a), int'(b)), a > b, a < b, a == b);
      @(negedge clk);
      chk({tag, " pulse width"}, {31'd0, done}, 32'd0);
      chk({tag, " hold"}, {29'd0, Greater, Less, Equal}, {29'd0, a > b, a < b, a == b});
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit           seen;

      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;

      // 1. reset and idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset idle outputs", {26'd0, busy, done, Greater, Less, Equal, digit_idx}, 32'd0);
      end

      // 2. MSB decides
      run_op("gt msb", 12'o7000, 12'o6777);
      // 3. LSB decides
      run_op("lt lsb", 12'o1234, 12'o1235);

      // 4. equal, then back-to-back with start held
      @(negedge clk);
      A     = 12'o5252;
      B     = 12'o5252;
      start = 1'b1;
      @(posedge clk);
      wait_done("eq", DIGITS + 1, 1'b0, 1'b0, 1'b1);
      A = 12'o0000;
      B = 12'o7777;
      @(negedge clk);
      chk("b2b idle gap", {30'd0, busy, done}, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("b2b lt", ref_latency(0, 'o7777), 1'b0, 1'b1, 1'b0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (busy) seen = 1;
      end
      chk("b2b no extra op", {31'd0, seen}, 32'd0);

      // 5a. operands change and start pulses during RUN
      @(negedge clk);
      A     = 12'o3000;
      B     = 12'o3001;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      A = 12'o7777;
      B = 12'o0000;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("run start ignored", DIGITS + 1 - 2, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("start not queued", {31'd0, busy}, 32'd0);

      // 5b. reset mid-RUN
      @(negedge clk);
      A     = 12'o4000;
      B     = 12'o1000;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrun reset outputs", {26'd0, busy, done, Greater, Less, Equal, digit_idx}, 32'd0);
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("midrun reset no done", {31'd0, seen}, 32'd0);

      // rst and start together: reset wins
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("rst beats start", {31'd0, busy}, 32'd0);

      run_op("after reset", 12'o4000, 12'o1000);
      run_op("all ones vs zero", 12'o7777, 12'o0000);
      run_op("all zero equal", 12'o0000, 12'o0000);

      // 6. randomised sweep with biased operand relations
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom);
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = (ra & 12'o7700) | W'($urandom_range(0, 'o77));
            2: rb = (ra & 12'o7770) | W'($urandom_range(0, 7));
            default: rb = W'($urandom);
         endcase
         run_op("sweep", ra, rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   // The bench must always end even if the DUT misbehaves.
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
